router_pkt_tx: RTL

Packet source for the 1x3 router input port. It accepts a command (destination address, payload length, error-inject flag) plus a byte stream of payload. It then drives the router's pkt_valid/data_in protocol: header byte, payload bytes, then the parity byte. It honours the router's busy back-pressure and reports the router's parity-error response per packet. It is used as the upstream block in the SoC and as the synthesizable stimulus source in router regressions.

---
 rtl/router_pkg.sv | 8 +
 rtl/router_parity_gen.sv | 19 +
 rtl/router_pkt_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared FSM states, header field layout and defaults for the router packet source
package router_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB = 2;
  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
endpackage

// File: rtl/router_parity_gen.sv
// router_parity_gen: running-XOR accumulator; ports clock/reset, load (priority), hold, en, din -> parity
module router_parity_gen
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic              hold,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] parity
);
  always_ff @(posedge clock)
    if (reset) parity <= '0;
    else if (load) parity <= din;
    else if (en && !hold) parity <= parity ^ din;
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: command + payload stream in, router pkt_valid/data_out (header, payload, parity, gap) out, done/parity_err/underrun/cmd_drop status
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = 6,
  parameter int ADDR_W = 2,
  parameter int IPG    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_inject,
  input  logic              pl_valid,
  input  logic [DATA_W-1:0] pl_data,
  output logic              pl_ready,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              parity_err,
  output logic              underrun,
  output logic              cmd_drop
);
  localparam int GAP_W = $clog2(IPG) + 1;
  state_t state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic inject, inject_n, und, und_n, perr, perr_n, pv_n, drop_n;
  logic [DATA_W-1:0] data_n, hdr, pl_byte, parity;
  logic accept, legal, fetch, par_load;
  router_parity_gen #(.DATA_W(DATA_W)) u_par (
    .clock (clock),
    .reset (reset),
    .load  (par_load),
    .en    (fetch),
    .hold  (busy),
    .din   (par_load ? hdr : pl_byte),
    .parity(parity)
  );
  assign cmd_ready  = state == IDLE;
  assign accept     = cmd_valid && cmd_ready;
  assign legal      = cmd_addr != ADDR_W'(ADDR_ILLEGAL) && cmd_len != '0;
  assign par_load   = accept && legal;
  assign fetch      = (state == HEADER || state == PAYLOAD) && cnt != '0 && !busy;
  assign pl_ready   = fetch;
  assign pl_byte    = pl_valid ? pl_data : '0;
  // the final gap cycle also observes err live so a late router flag is not lost
  assign done       = state == GAP && gap == '0 && !busy;
  assign parity_err = done && (perr || err);
  assign underrun   = done && und;
  always_comb begin
    hdr = '0;
    hdr[HDR_ADDR_LSB +: ADDR_W] = cmd_addr;
    hdr[HDR_LEN_LSB +: LEN_W]   = cmd_len;
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gap_n    = gap;
    inject_n = inject;
    data_n   = data_out;
    pv_n     = pkt_valid;
    und_n    = und;
    perr_n   = perr || ((state == PARITY || state == GAP) && err);
    drop_n   = accept && !legal;
    case (state)
      IDLE:
        if (par_load) begin
          state_n  = HEADER;
          cnt_n    = cmd_len;
          inject_n = cmd_inject;
          data_n   = hdr;
          pv_n     = 1'b1;
        end
      HEADER, PAYLOAD:
        if (fetch) begin
          state_n = PAYLOAD;
          cnt_n   = cnt - LEN_W'(1);
          data_n  = pl_byte;
          und_n   = und || !pl_valid;
        end else if (!busy && state == PAYLOAD) begin
          state_n = PARITY;
          data_n  = parity ^ DATA_W'(inject);
          pv_n    = 1'b0;
        end
      PARITY:
        if (!busy) begin
          state_n = GAP;
          data_n  = '0;
          gap_n   = GAP_W'(IPG - 1);
        end
      GAP:
        if (!busy) begin
          if (gap == '0) begin
            state_n = IDLE;
            und_n   = 1'b0;
            perr_n  = 1'b0;
          end else gap_n = gap - GAP_W'(1);
        end
      default: ;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gap       <= '0;
      inject    <= 1'b0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      und       <= 1'b0;
      perr      <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gap       <= gap_n;
      inject    <= inject_n;
      data_out  <= data_n;
      pkt_valid <= pv_n;
      und       <= und_n;
      perr      <= perr_n;
      cmd_drop  <= drop_n;
    end
endmodule
